c_fetch_unit: RTL

Instruction-fetch stage. Owns the fetch PC and issues in-order requests to instruction memory over a req/gnt/rvalid handshake, with variable latency. Buffers returned words in a small queue and presents the head instruction, its PC and the pre-split `op`/`funct3`/`funct7b5` fields to the IF/ID pipeline registers. Supports stall from the hazard unit and redirect from EX (taken branch/jump), and discards in-flight responses from the old stream.

---
 rtl/c_fetch_unit_if.sv | 25 ++
 rtl/c_fetch_unit.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/c_fetch_unit_if.sv
// c_fetch_unit_if: instruction-memory request/response bundle.
// Ports: imem_req_o/imem_addr_o (fetch -> mem), imem_gnt_i/imem_rvalid_i/imem_rdata_i (mem -> fetch).
interface c_fetch_unit_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/c_fetch_unit.sv
// c_fetch_unit: fetch stage issuing in-order imem requests, buffering
// returned words and presenting the head instruction to IF/ID.
// Ports: clk, reset (async, active-high), StallF, redirect_i, redirect_pc_i,
//   imem (c_fetch_unit_if.master), valid_F, instr_F, pc_F, op_F, funct3_F, funct7b5_F.
// Config: FETCH_PREFETCH_EN defined -> 2-entry queue / 2 outstanding,
//   undefined -> single holding register / 1 outstanding.
module c_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           StallF,
    input  logic           redirect_i,
    input  logic [31:0]    redirect_pc_i,
    c_fetch_unit_if.master imem,
    output logic           valid_F,
    output logic [31:0]    instr_F,
    output logic [31:0]    pc_F,
    output logic [6:0]     op_F,
    output logic [2:0]     funct3_F,
    output logic           funct7b5_F
);

`ifdef FETCH_PREFETCH_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif
    localparam int CW = $clog2(CAP + 1);
    localparam int PW = (CAP > 1) ? $clog2(CAP) : 1;

    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [CW:0]   CAP_LV = (CW + 1)'(CAP);
    localparam logic [PW-1:0] LAST   = PW'(CAP - 1);

    logic [31:0]   r_req_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_disc;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [31:0]   r_q_pc   [CAP];
    logic [31:0]   r_q_word [CAP];

    logic [CW:0]   w_inflight;
    logic          w_req;
    logic          w_gnt;
    logic          w_rv;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic          w_valid;
    logic [31:0]   w_tgt;
    logic [31:0]   w_instr;
    logic [PW-1:0] w_head_nx;
    logic [PW-1:0] w_tail_nx;

    // Slots reserved by in-flight requests count against capacity so a
    // returning word always has room.
    assign w_inflight = {1'b0, r_out} + {1'b0, r_count};
    assign w_req      = !reset && !redirect_i && (w_inflight < CAP_LV);
    assign w_gnt      = w_req && imem.imem_gnt_i;
    assign w_rv       = imem.imem_rvalid_i;
    assign w_drop     = w_rv && (r_disc != '0);
    assign w_push     = w_rv && !w_drop && !redirect_i;
    assign w_valid    = (r_count != '0);
    assign w_pop      = w_valid && !StallF && !redirect_i;
    assign w_tgt      = {redirect_pc_i[31:2], 2'b00};

    assign w_head_nx = (r_head == LAST) ? '0 : r_head + PW'(1);
    assign w_tail_nx = (r_tail == LAST) ? '0 : r_tail + PW'(1);

    assign imem.imem_req_o  = w_req;
    assign imem.imem_addr_o = r_req_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_pc  <= RESET_PC;
            r_resp_pc <= RESET_PC;
            r_out     <= '0;
            r_disc    <= '0;
            r_count   <= '0;
            r_head    <= '0;
            r_tail    <= '0;
        end else if (redirect_i) begin
            // A word returning this cycle belongs to the old stream.
            r_req_pc  <= w_tgt;
            r_resp_pc <= w_tgt;
            r_out     <= r_out - CW'(w_rv);
            r_disc    <= r_out - CW'(w_rv);
            r_count   <= '0;
            r_head    <= '0;
            r_tail    <= '0;
        end else begin
            if (w_gnt) begin
                r_req_pc <= r_req_pc + 32'd4;
            end

            unique case ({w_gnt, w_rv})
                2'b10:   r_out <= r_out + ONE;
                2'b01:   r_out <= r_out - ONE;
                default: r_out <= r_out;
            endcase

            if (w_drop) begin
                r_disc <= r_disc - ONE;
            end

            if (w_push) begin
                r_resp_pc <= r_resp_pc + 32'd4;
                r_tail    <= w_tail_nx;
            end

            if (w_pop) begin
                r_head <= w_head_nx;
            end

            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + ONE;
                2'b01:   r_count <= r_count - ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue payload needs no reset; occupancy is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_tail]   <= r_resp_pc;
            r_q_word[r_tail] <= imem.imem_rdata_i;
        end
    end

    assign w_instr    = w_valid ? r_q_word[r_head] : NOP_INSTR;
    assign valid_F    = w_valid;
    assign instr_F    = w_instr;
    assign pc_F       = w_valid ? r_q_pc[r_head] : 32'd0;
    assign op_F       = w_instr[6:0];
    assign funct3_F   = w_instr[14:12];
    assign funct7b5_F = w_instr[30];

endmodule
